keypad_time_loader: RTL

KEYPAD_TIME_LOADER -- requirements
Module: keypad_time_loader

---
 rtl/keypad_time_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/keypad_time_loader.sv
// Keypad time-entry loader: shifts BCD digits into a 4-digit MM:SS buffer and strobes it downstream.
// Optional key debounce is enabled by defining KEYPAD_KEY_DEBOUNCE_EN.
module keypad_time_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_pressed,
  input  logic        start,
  input  logic        clear,
  output logic [15:0] time_out,
  output logic [2:0]  digit_count,
  output logic        load_pulse,
  output logic        entry_active
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        key_accept;
  logic        key_digit;

`ifdef KEYPAD_KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] db_cnt;
  logic          armed;

  // Counter saturates at DEBOUNCE_CYCLES; armed only returns after a low sample,
  // so a key held through reset or held long never shifts twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      armed  <= 1'b0;
    end else if (!key_pressed) begin
      db_cnt <= '0;
      armed  <= 1'b1;
    end else begin
      if (db_cnt != CW'(DEBOUNCE_CYCLES)) db_cnt <= db_cnt + 1'b1;
      if (key_accept) armed <= 1'b0;
    end
  end

  assign key_accept = key_pressed && armed && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));
`else
  logic key_q;

  // Reset treats the key as already down so a held key needs a release first.
  always_ff @(posedge clk) begin
    if (rst) key_q <= 1'b1;
    else     key_q <= key_pressed;
  end

  assign key_accept = key_pressed && !key_q;
`endif

  assign key_digit = key_accept && (key_code <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      time_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = EMPTY;
      time_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (key_digit) begin
            state_d = ENTRY;
            time_d  = {time_q[11:0], key_code};
            cnt_d   = 3'd1;
          end
        end
        ENTRY: begin
          // A start that wins the edge swallows any simultaneous key press.
          if (start && (time_q != 16'h0000)) begin
            state_d = LOAD;
          end else if (key_digit) begin
            time_d  = {time_q[11:0], key_code};
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd3) ? FULL : ENTRY;
          end
        end
        FULL: begin
          if (start && (time_q != 16'h0000)) state_d = LOAD;
        end
        LOAD: begin
          state_d = EMPTY;
          time_d  = '0;
          cnt_d   = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    time_out     = time_q;
    digit_count  = cnt_q;
    load_pulse   = (state_q == LOAD);
    entry_active = (state_q != EMPTY);
  end

endmodule
